// File: rtl/theta_ramp_gen.sv
// theta_ramp_gen: linear ramp from +1.0 down to -1.0 over N points.
// A restoring divider derives the per-point step once per configuration;
// a two-stage pipeline then turns indices (external or auto-generated
// sawtooth/triangle) into signed Q2.FRAC_W values.

module theta_ramp_gen #(
    parameter int FRAC_W = 32,
    parameter int PTS_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     nrst_i,
    input  logic                     cfg_valid_i,
    input  logic [PTS_W-1:0]         cfg_points_i,
    input  logic [1:0]               cfg_mode_i,
    output logic                     cfg_ready_o,
    output logic                     busy_o,
    output logic                     cfg_err_o,
    input  logic                     it_valid_i,
    input  logic [PTS_W-1:0]         it_i,
    output logic                     it_ready_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [FRAC_W+1:0] out_o,
    output logic [PTS_W-1:0]         out_idx_o,
    output logic                     range_err_o
);

    localparam int STEP_W = FRAC_W + 2;
    localparam int PROD_W = PTS_W + STEP_W;
    localparam int RES_W  = PROD_W + 1;
    localparam int CNT_W  = $clog2(STEP_W);

    localparam logic signed [RES_W-1:0] POS_ONE =
        {{(RES_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
    localparam logic signed [RES_W-1:0] NEG_ONE = -POS_ONE;
    localparam logic signed [STEP_W-1:0] NEG_OUT = NEG_ONE[STEP_W-1:0];

    typedef enum logic [1:0] {IDLE, CALC, RUN} state_t;
    typedef enum logic [1:0] {MODE_EXT = 2'd0, MODE_SAW = 2'd1, MODE_TRI = 2'd2} mode_t;

    state_t              state;
    mode_t               mode;
    logic [PTS_W-1:0]    nPts;
    logic [STEP_W-1:0]   step;
    logic [PTS_W-1:0]    divRem;
    logic [CNT_W-1:0]    divCnt;
    logic [PTS_W-1:0]    autoIdx;
    logic                autoUp;

    logic                s1Valid;
    logic [PROD_W-1:0]   s1Prod;
    logic [PTS_W-1:0]    s1Idx;
    logic                s1Last;
    logic                s1Range;

    logic                en;
    logic                cfgAccept;
    logic                cfgOk;
    logic                runEn;
    logic                autoMode;
    logic                issue;
    logic [PTS_W-1:0]    issueIdx;
    logic [PTS_W-1:0]    lastIdx;
    logic                divBit;
    logic [PTS_W:0]      divTrial;
    logic                divFits;
    logic signed [RES_W-1:0]  diff;
    logic signed [STEP_W-1:0] result;

    assign en         = !out_valid_o || out_ready_i;
    assign cfgAccept  = cfg_valid_i && cfg_ready_o;
    assign cfgOk      = cfg_points_i >= PTS_W'(2);
    assign runEn      = (state == RUN) && en;
    assign autoMode   = (mode != MODE_EXT);
    assign it_ready_o = runEn && !autoMode;
    assign issue      = runEn && (autoMode || it_valid_i);
    assign issueIdx   = autoMode ? autoIdx : it_i;
    assign lastIdx    = nPts - PTS_W'(1);

    // Dividend 2^(FRAC_W+1) has a single set bit, fed in on the first iteration.
    assign divBit   = (divCnt == '0);
    assign divTrial = {divRem, divBit};
    assign divFits  = divTrial >= {1'b0, lastIdx};

    // Control FSM: config handshake, step divider and busy/ready flags.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state       <= IDLE;
            mode        <= MODE_EXT;
            nPts        <= '0;
            step        <= '0;
            divRem      <= '0;
            divCnt      <= '0;
            cfg_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            cfg_err_o   <= 1'b0;
        end else if (cfgAccept) begin
            if (cfgOk) begin
                cfg_err_o   <= 1'b0;
                nPts        <= cfg_points_i;
                mode        <= (cfg_mode_i == 2'd3) ? MODE_EXT : mode_t'(cfg_mode_i);
                step        <= '0;
                divRem      <= '0;
                divCnt      <= '0;
                state       <= CALC;
                cfg_ready_o <= 1'b0;
                busy_o      <= 1'b1;
            end else begin
                cfg_err_o   <= 1'b1;
                state       <= IDLE;
                cfg_ready_o <= 1'b1;
                busy_o      <= 1'b0;
            end
        end else if (state == CALC) begin
            step   <= {step[STEP_W-2:0], divFits};
            divRem <= divFits ? PTS_W'(divTrial - {1'b0, lastIdx}) : divTrial[PTS_W-1:0];
            divCnt <= divCnt + CNT_W'(1);
            if (divCnt == CNT_W'(STEP_W - 1)) begin
                state       <= RUN;
                cfg_ready_o <= 1'b1;
                busy_o      <= 1'b0;
            end
        end
    end

    // Auto index generator: sawtooth wraps, triangle bounces without repeating endpoints.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            autoIdx <= '0;
            autoUp  <= 1'b1;
        end else if (cfgAccept) begin
            autoIdx <= '0;
            autoUp  <= 1'b1;
        end else if (runEn && autoMode) begin
            if (mode == MODE_SAW) begin
                autoIdx <= (autoIdx == lastIdx) ? '0 : autoIdx + PTS_W'(1);
            end else if (autoUp) begin
                if (autoIdx == lastIdx) begin
                    autoUp  <= 1'b0;
                    autoIdx <= autoIdx - PTS_W'(1);
                end else begin
                    autoIdx <= autoIdx + PTS_W'(1);
                end
            end else begin
                if (autoIdx == '0) begin
                    autoUp  <= 1'b1;
                    autoIdx <= autoIdx + PTS_W'(1);
                end else begin
                    autoIdx <= autoIdx - PTS_W'(1);
                end
            end
        end
    end

    // Stage 1: register idx*step plus last-point and out-of-range flags.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            s1Valid <= 1'b0;
            s1Prod  <= '0;
            s1Idx   <= '0;
            s1Last  <= 1'b0;
            s1Range <= 1'b0;
        end else if (cfgAccept) begin
            s1Valid <= 1'b0;
        end else if (en) begin
            s1Valid <= issue;
            if (issue) begin
                s1Prod  <= PROD_W'(issueIdx) * PROD_W'(step);
                s1Idx   <= issueIdx;
                s1Last  <= (issueIdx == lastIdx);
                s1Range <= (issueIdx >= nPts);
            end
        end
    end

    // Result: 1.0 - prod, clamped, with exact -1.0 at the last point or out of range.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        result = NEG_OUT;
        diff   = POS_ONE - $signed({1'b0, s1Prod});
        if (s1Last || s1Range || (diff < NEG_ONE)) begin
            result = NEG_OUT;
        end else if (diff > POS_ONE) begin
            result = POS_ONE[STEP_W-1:0];
        end else begin
            result = diff[STEP_W-1:0];
        end
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            out_valid_o <= 1'b0;
            out_o       <= '0;
            out_idx_o   <= '0;
            range_err_o <= 1'b0;
        end else if (cfgAccept) begin
            out_valid_o <= 1'b0;
        end else if (en) begin
            out_valid_o <= s1Valid;
            if (s1Valid) begin
                out_o       <= result;
                out_idx_o   <= s1Idx;
                range_err_o <= s1Range;
            end
        end
    end

endmodule

// File: doc/theta_ramp_gen.md
THETA_RAMP_GEN -- requirements
Module: theta_ramp_gen

Interface
REQ-001 SHALL have parameter FRAC_W, default 32: fractional bits of the step and of the output.
REQ-002 SHALL have parameter PTS_W, default 16: width of the point count, iteration index and output index.
REQ-003 SHALL have ports clk_i, in, 1, clock; nrst_i, in, 1, reset (asynchronous, active-low).
REQ-004 SHALL have ports cfg_valid_i, in, 1, config strobe; cfg_points_i, in, PTS_W, total points N; cfg_mode_i, in, 2, 0=external / 1=auto sawtooth / 2=auto triangle / 3=reserved, treated as 0.
REQ-005 SHALL have ports cfg_ready_o, out, 1, config accepted this cycle; busy_o, out, 1, step computation running; cfg_err_o, out, 1, last config invalid.
REQ-006 SHALL have ports it_valid_i, in, 1, index valid; it_i, in, PTS_W, iteration index; it_ready_o, out, 1, index accepted.
REQ-007 SHALL have ports out_valid_o, out, 1, result valid; out_ready_i, in, 1, consumer ready; out_o, out, FRAC_W+2, signed Q2.FRAC_W result; out_idx_o, out, PTS_W, index of result; range_err_o, out, 1, result came from it_i >= N.

Function
REQ-008 SHALL implement states IDLE, CALC, RUN.
REQ-009 SHALL drive cfg_ready_o=1 in IDLE and RUN, 0 in CALC; a config is accepted when cfg_valid_i && cfg_ready_o.
REQ-010 SHALL, on accepting N<2, set cfg_err_o=1 and go to or stay in IDLE; on accepting N>=2, clear cfg_err_o, latch N and mode, go to CALC.
REQ-011 SHALL in CALC run a restoring divider, one quotient bit per cycle, for exactly FRAC_W+2 cycles: step = floor(2^(FRAC_W+1)/(N-1)), unsigned, FRAC_W+2 bits; busy_o=1 only in CALC; then enter RUN.
REQ-012 SHALL, on accepting a config in RUN, flush both pipeline stages (out_valid_o=0 next cycle) and restart CALC.
REQ-013 SHALL use a two-stage pipeline with common enable en = !out_valid_o || out_ready_i: S1 registers prod = idx*step; S2 registers the result.
REQ-014 SHALL compute result = 2^FRAC_W - prod using full-width signed arithmetic, then clamp to [-2^FRAC_W, +2^FRAC_W].
REQ-015 SHALL force result = -2^FRAC_W exactly when idx == N-1, removing truncation error at the last point.
REQ-016 SHALL, when idx >= N, output -2^FRAC_W with range_err_o=1 on that result only.
REQ-017 SHALL in mode 0 drive it_ready_o = (state==RUN) && en; otherwise it_ready_o=0.
REQ-018 SHALL in modes 1/2 generate idx internally, advancing one per cycle while RUN && en, starting at 0 after each CALC.
REQ-019 SHALL in mode 1 wrap N-1 -> 0.
REQ-020 SHALL in mode 2 reverse direction at N-1 and at 0 without repeating endpoints (0,1,...,N-1,N-2,...,1,0,1,...).
REQ-021 SHALL have latency exactly 2 cycles from index accept (or auto issue) to out_valid_o when out_ready_i stays 1, with throughput 1 result/cycle.
REQ-022 SHALL hold out_o, out_idx_o and range_err_o stable while out_valid_o && !out_ready_i; no result dropped or duplicated.

Reset
REQ-023 SHALL, while nrst_i=0, drive state IDLE, step=0, N=0, mode=0, cfg_ready_o=1, busy_o=0, cfg_err_o=0, it_ready_o=0, out_valid_o=0, out_o=0, out_idx_o=0, range_err_o=0, and clear the pipeline and auto counter.
REQ-024 SHALL, on reset assertion mid-CALC or mid-RUN, discard all in-flight data; after release, no output until a new config completes.

Verification
REQ-025 SHALL verify: F=32, N=1800, mode 0, out_ready=1; it=0,1,900,1799 -> step=4774838; out=4294967296, 4290192458, -2386904, -4294967296; each 2 cycles after accept.
REQ-026 SHALL verify: N=3 -> busy_o high exactly 34 cycles, step=2^32; it=1 -> out=0; it=5 -> out=-2^32 with range_err_o=1.
REQ-027 SHALL verify: N=1 and N=0 -> cfg_err_o=1, state stays IDLE, it_ready_o=0, no outputs.
REQ-028 SHALL verify: mode 2, N=4 -> out_idx_o sequence 0,1,2,3,2,1,0,1; out_ready_i held low 3 cycles mid-stream -> outputs frozen, sequence unbroken.
REQ-029 SHALL verify: new config (N=1800 -> N=3) accepted in RUN with results in flight -> out_valid_o=0 the next cycle, none of the old results delivered, first new result idx 0 = 2^32.
REQ-030 SHALL verify: nrst_i pulsed low during CALC -> all outputs at reset values; no output until a fresh config completes.
